cu_mem_unit: RTL

CU_MEM_UNIT -- requirements
Module: cu_mem_unit

---
 rtl/cu_mem_unit.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/cu_mem_unit.sv
// CU memory-stage unit: accepts one load/store per request, drives a simple
// request/acknowledge MMU port and returns the extended load result or an error code.
module cu_mem_unit #(
  parameter int ADDR_W  = 7,
  parameter int TIMEOUT = 15
) (
  input  logic              soc_clk,
  input  logic              soc_reset,
  input  logic [1:0]        stage_counter,
  input  logic              memfetch_start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        funct3,
  input  logic              read_or_write,
  input  logic [31:0]       wdata,
  output logic              mmu_req,
  output logic              mmu_we,
  output logic [ADDR_W-1:0] mmu_addr,
  output logic [3:0]        mmu_be,
  output logic [31:0]       mmu_wdata,
  input  logic              mmu_ack,
  input  logic [31:0]       mmu_rdata,
  output logic [31:0]       MEM_data,
  output logic              MEM_valid,
  output logic              MEM_busy,
  output logic [1:0]        MEM_err
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;
  localparam logic [1:0] ST_ERR    = 2'd3;

  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_FUNCT3   = 2'b11;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] lat_addr;
  logic [2:0]        lat_funct3;
  logic              lat_write;
  logic [31:0]       lat_wdata;
  logic [7:0]        wait_cnt;
  logic [1:0]        err_code;
  logic [31:0]       mem_data_q;

  logic              accept;
  logic              illegal_f3;
  logic              misaligned;
  logic              in_access;
  logic [1:0]        lane;
  logic [3:0]        lane_be;
  logic [31:0]       rep_wdata;
  logic [31:0]       shifted_rdata;
  logic [31:0]       load_ext;

  assign accept    = (state == ST_IDLE) && memfetch_start && (stage_counter == 2'b00);
  assign in_access = (state == ST_ACCESS);
  assign lane      = lat_addr[1:0];

  // Classify the incoming request before it is latched.
  always_comb begin
    illegal_f3 = 1'b1;
    case (funct3)
      3'b000, 3'b001, 3'b010: illegal_f3 = 1'b0;
      3'b100, 3'b101:         illegal_f3 = read_or_write;
      default:                illegal_f3 = 1'b1;
    endcase
    misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                 ((funct3 == 3'b010) && (addr[1:0] != 2'b00));
  end

  always_comb begin
    lane_be   = 4'b1111;
    rep_wdata = lat_wdata;
    case (lat_funct3[1:0])
      2'b00: begin
        lane_be   = 4'b0001 << lane;
        rep_wdata = {4{lat_wdata[7:0]}};
      end
      2'b01: begin
        lane_be   = 4'b0011 << lane;
        rep_wdata = {2{lat_wdata[15:0]}};
      end
      default: begin
        lane_be   = 4'b1111;
        rep_wdata = lat_wdata;
      end
    endcase
  end

  // Bring the addressed lane down to bit 0, then extend by access kind.
  always_comb begin
    shifted_rdata = mmu_rdata >> {lane, 3'b000};
    load_ext      = mmu_rdata;
    case (lat_funct3)
      3'b000:  load_ext = {{24{shifted_rdata[7]}}, shifted_rdata[7:0]};
      3'b001:  load_ext = {{16{shifted_rdata[15]}}, shifted_rdata[15:0]};
      3'b100:  load_ext = {24'd0, shifted_rdata[7:0]};
      3'b101:  load_ext = {16'd0, shifted_rdata[15:0]};
      default: load_ext = mmu_rdata;
    endcase
  end

  always_ff @(posedge soc_clk) begin
    if (soc_reset) begin
      state      <= ST_IDLE;
      lat_addr   <= '0;
      lat_funct3 <= 3'd0;
      lat_write  <= 1'b0;
      lat_wdata  <= 32'd0;
      wait_cnt   <= 8'd0;
      err_code   <= 2'b00;
      mem_data_q <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            lat_addr   <= addr;
            lat_funct3 <= funct3;
            lat_write  <= read_or_write;
            lat_wdata  <= wdata;
            wait_cnt   <= 8'd0;
            if (illegal_f3) begin
              state    <= ST_ERR;
              err_code <= ERR_FUNCT3;
            end else if (misaligned) begin
              state    <= ST_ERR;
              err_code <= ERR_MISALIGN;
            end else begin
              state    <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          // An ack on the last permitted cycle still completes the access.
          if (mmu_ack) begin
            state <= ST_DONE;
            if (!lat_write) mem_data_q <= load_ext;
          end else if (wait_cnt == TIMEOUT_LAST) begin
            state    <= ST_ERR;
            err_code <= ERR_TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mmu_req   = in_access;
  assign mmu_we    = in_access && lat_write;
  assign mmu_be    = in_access ? lane_be : 4'b0000;
  assign mmu_addr  = {lat_addr[ADDR_W-1:2], 2'b00};
  assign mmu_wdata = rep_wdata;
  assign MEM_data  = mem_data_q;
  assign MEM_valid = (state == ST_DONE);
  assign MEM_busy  = (state != ST_IDLE);
  assign MEM_err   = (state == ST_ERR) ? err_code : 2'b00;

endmodule
